// File: rtl/frame_timer_bank.sv
// frame_timer_bank: bank of independent frame-rate timers.
//
// Each channel runs its own Idle/Run/Done FSM on the shared frame_clk and
// counts frames up to a live-sampled limit. On reaching the limit, one of two
// things happens, and either way expire_pulse fires for one cycle:
//   - a one-shot channel latches expired;
//   - a periodic channel reloads its count to 0.
//
// Optional feature:
//   FRAME_TIMER_PERIODIC_EN: when defined, the periodic input selects
//   auto-reload per channel. When undefined, the periodic port is ignored, all
//   channels are one-shot, and no reload logic is built.
//
// Ports:
//   frame_clk    : clock, one rising edge per video frame
//   Reset        : asynchronous, active-high reset
//   start        : [NUM_CH] per-channel run request (level); low clears the channel
//   pause        : [NUM_CH] per-channel hold of count/state/expired
//   periodic     : [NUM_CH] per-channel mode, 0 = one-shot, 1 = auto-reload
//   limit        : [NUM_CH*CNT_W] per-channel terminal value, channel i at [i*CNT_W +: CNT_W]
//   count        : [NUM_CH*CNT_W] per-channel current count, same packing as limit
//   expired      : [NUM_CH] one-shot terminal state reached
//   expire_pulse : [NUM_CH] single-cycle event on every terminal hit
//   any_expired  : registered OR of expired
module frame_timer_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] limit,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       expire_pulse,
  output logic                    any_expired
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   count_q [NUM_CH];
  logic [CNT_W-1:0]   count_d [NUM_CH];
  logic [CNT_W-1:0]   lim     [NUM_CH];
  logic [NUM_CH-1:0]  expired_q, expired_d;
  logic [NUM_CH-1:0]  pulse_q, pulse_d;
  logic [NUM_CH-1:0]  reload;
  logic               any_q;

`ifdef FRAME_TIMER_PERIODIC_EN
  assign reload = periodic;
`else
  // Periodic mode is compiled out; keep the port but tie reload off.
  logic unused_periodic;
  assign unused_periodic = ^periodic;
  assign reload          = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_io
    assign lim[g]                     = limit[g*CNT_W +: CNT_W];
    assign count[g*CNT_W +: CNT_W]    = count_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      count_d[i]   = count_q[i];
      expired_d[i] = expired_q[i];
      pulse_d[i]   = 1'b0;
      if (!start[i]) begin
        // Dropping start clears the channel whatever its state or pause.
        state_d[i]   = StIdle;
        count_d[i]   = '0;
        expired_d[i] = 1'b0;
      end else if (!pause[i]) begin
        unique case (state_q[i])
          // Idle joins Run on the same edge, so both take the run rule.
          StIdle, StRun: begin
            // >= so a limit lowered below the count still hits terminal.
            if (count_q[i] >= lim[i]) begin
              pulse_d[i] = 1'b1;
              if (reload[i]) begin
                count_d[i] = '0;
                state_d[i] = StRun;
              end else begin
                state_d[i]   = StDone;
                expired_d[i] = 1'b1;
              end
            end else begin
              count_d[i] = count_q[i] + CNT_W'(1);
              state_d[i] = StRun;
            end
          end
          StDone: begin
            state_d[i] = StDone;
          end
          default: begin
            state_d[i] = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        count_q[i] <= '0;
      end
      expired_q <= '0;
      pulse_q   <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      any_q     <= |expired_q;
    end
  end

  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign any_expired  = any_q;

endmodule

// File: tb/tb_frame_timer_bank.sv
// Self-checking bench for frame_timer_bank (default parameters).
// Expected per-edge values are pushed to a scoreboard queue before each
// scenario runs and popped and compared as each frame edge completes.
module tb_frame_timer_bank;

  localparam int NCH = 4;
  localparam int CW  = 10;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic [NCH-1:0]    start, pause, periodic;
  logic [NCH*CW-1:0] limit, count;
  logic [NCH-1:0]    expired, expire_pulse;
  logic              any_expired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            edge_n;
    int            ch;
    logic [CW-1:0] cnt;
    logic          exp;
    logic          pls;
    logic          any;
    bit            chk_any;
  } exp_t;

  exp_t sb[$];

  frame_timer_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .start        (start),
    .pause        (pause),
    .periodic     (periodic),
    .limit        (limit),
    .count        (count),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .any_expired  (any_expired)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic void push(int n, int ch, int cnt, logic ex, logic p,
                               logic any = 1'b0, bit chk_any = 1'b0);
    exp_t e;
    e.edge_n = n; e.ch = ch; e.cnt = CW'(cnt); e.exp = ex; e.pls = p;
    e.any = any; e.chk_any = chk_any;
    sb.push_back(e);
  endfunction

  task automatic edge_wait();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle_all();
    start = '0; pause = '0; periodic = '0;
    edge_wait();
    edge_wait();
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = '0; pause = '0; periodic = '0; limit = '0;
    #12;
    checks++; if (count !== '0) begin errors++;
      $display("FAIL reset_count: got %h want 0", count); end
    checks++; if (expired !== '0) begin errors++;
      $display("FAIL reset_expired: got %b want 0", expired); end
    checks++; if (expire_pulse !== '0) begin errors++;
      $display("FAIL reset_pulse: got %b want 0", expire_pulse); end
    checks++; if (any_expired !== 1'b0) begin errors++;
      $display("FAIL reset_any: got %b want 0", any_expired); end
    Reset = 1'b0;
    edge_wait();
  endtask

  task automatic test_oneshot();
    exp_t e;
    limit[0*CW +: CW] = CW'(181); start[0] = 1'b1;
    push(1, 0, 1, 0, 0, 0, 1);
    push(181, 0, 181, 0, 0, 0, 1);
    push(182, 0, 181, 1, 1, 0, 1);
    push(183, 0, 181, 1, 0, 1, 1);
    for (int n = 1; n <= 183; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL oneshot_count e%0d: got %0d want %0d", n, count[e.ch*CW +: CW], e.cnt); end
        checks++; if (expired[e.ch] !== e.exp) begin errors++;
          $display("FAIL oneshot_expired e%0d: got %b want %b", n, expired[e.ch], e.exp); end
        checks++; if (expire_pulse[e.ch] !== e.pls) begin errors++;
          $display("FAIL oneshot_pulse e%0d: got %b want %b", n, expire_pulse[e.ch], e.pls); end
        if (e.chk_any) begin
          checks++; if (any_expired !== e.any) begin errors++;
            $display("FAIL oneshot_any e%0d: got %b want %b", n, any_expired, e.any); end
        end
      end
    end
    idle_all();
  endtask

  task automatic test_periodic();
    exp_t e;
    limit[1*CW +: CW] = CW'(3); periodic[1] = 1'b1; start[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
`ifdef FRAME_TIMER_PERIODIC_EN
      push(n, 1, n % 4, 1'b0, (n % 4) == 0);
`else
      push(n, 1, (n < 4) ? n : 3, n >= 4, n == 4);
`endif
    end
    for (int n = 1; n <= 8; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL periodic_count e%0d: got %0d want %0d", n, count[e.ch*CW +: CW], e.cnt); end
        checks++; if (expired[e.ch] !== e.exp) begin errors++;
          $display("FAIL periodic_expired e%0d: got %b want %b", n, expired[e.ch], e.exp); end
        checks++; if (expire_pulse[e.ch] !== e.pls) begin errors++;
          $display("FAIL periodic_pulse e%0d: got %b want %b", n, expire_pulse[e.ch], e.pls); end
      end
    end
    idle_all();
  endtask

  task automatic test_pause();
    exp_t e;
    limit[2*CW +: CW] = CW'(10); start[2] = 1'b1;
    for (int n = 1; n <= 13; n++)
      push(n, 2, (n <= 4) ? n : (n <= 7) ? 4 : n - 3, 1'b0, 1'b0);
    push(14, 2, 10, 1'b1, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL pause_count e%0d: got %0d want %0d", n, count[e.ch*CW +: CW], e.cnt); end
        checks++; if (expired[e.ch] !== e.exp) begin errors++;
          $display("FAIL pause_expired e%0d: got %b want %b", n, expired[e.ch], e.exp); end
        checks++; if (expire_pulse[e.ch] !== e.pls) begin errors++;
          $display("FAIL pause_pulse e%0d: got %b want %b", n, expire_pulse[e.ch], e.pls); end
      end
      // Pause is high across edges 5..7.
      pause[2] = (n + 1 >= 5) && (n + 1 <= 7);
    end
    idle_all();
  endtask

  task automatic test_done_restart();
    exp_t e;
    limit[3*CW +: CW] = CW'(2); start[3] = 1'b1;
    push(1, 3, 1, 0, 0); push(2, 3, 2, 0, 0); push(3, 3, 2, 1, 1);
    push(4, 3, 2, 1, 0); push(5, 3, 0, 0, 0); push(6, 3, 1, 0, 0);
    for (int n = 1; n <= 6; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL done_count e%0d: got %0d want %0d", n, count[e.ch*CW +: CW], e.cnt); end
        checks++; if (expired[e.ch] !== e.exp) begin errors++;
          $display("FAIL done_expired e%0d: got %b want %b", n, expired[e.ch], e.exp); end
        checks++; if (expire_pulse[e.ch] !== e.pls) begin errors++;
          $display("FAIL done_pulse e%0d: got %b want %b", n, expire_pulse[e.ch], e.pls); end
      end
      start[3] = (n != 4);
    end
    idle_all();
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    for (int c = 0; c < NCH; c++) limit[c*CW +: CW] = CW'(200);
    start = '1;
    push(50, 0, 50, 0, 0);
    for (int c = 0; c < NCH; c++) push(51, c, 1, 0, 0);
    for (int n = 1; n <= 51; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL midrst_count e%0d ch%0d: got %0d want %0d", n, e.ch,
                   count[e.ch*CW +: CW], e.cnt); end
      end
      if (n == 50) begin
        #2 Reset = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++;
          $display("FAIL midrst_async_count: got %h want 0", count); end
        checks++; if ({expired, expire_pulse, any_expired} !== '0) begin errors++;
          $display("FAIL midrst_async_flags: got %b want 0", {expired, expire_pulse, any_expired}); end
        #1 Reset = 1'b0;
      end
    end
    idle_all();
  endtask

  task automatic test_limit_change();
    exp_t e;
    limit[0*CW +: CW] = CW'(100); start[0] = 1'b1;
    push(20, 0, 20, 0, 0);
    push(21, 0, 20, 1, 1);
    for (int n = 1; n <= 21; n++) begin
      edge_wait();
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        checks++; if (count[e.ch*CW +: CW] !== e.cnt) begin errors++;
          $display("FAIL limchg_count e%0d: got %0d want %0d", n, count[e.ch*CW +: CW], e.cnt); end
        checks++; if (expired[e.ch] !== e.exp) begin errors++;
          $display("FAIL limchg_expired e%0d: got %b want %b", n, expired[e.ch], e.exp); end
        checks++; if (expire_pulse[e.ch] !== e.pls) begin errors++;
          $display("FAIL limchg_pulse e%0d: got %b want %b", n, expire_pulse[e.ch], e.pls); end
      end
      if (n == 20) limit[0*CW +: CW] = CW'(5);
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_done_restart();
    test_reset_midrun();
    test_limit_change();
    checks++; if (sb.size() !== 0) begin errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
